sr_stack_ctrl: RTL and testbench

Controller for the hardware stack behind the `push`/`pop` instructions of `sr_cpu`. It keeps the top-of-stack in a register, backs the rest with a single-port synchronous RAM, and sequences refills after pops. It also shares that RAM between the CPU and a debug read port used by the board/testbench register-peek logic. The block sits beside `sr_cpu` inside `sm_top`, on the CPU clock.

---
 rtl/sr_stack_pkg.sv | 19 +
 rtl/sr_stack_ram.sv | 35 +++
 rtl/sr_stack_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_sr_stack_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_stack_pkg.sv
// Shared definitions for the sr_cpu hardware stack controller: FSM state
// encodings, default geometry and the debug age-counter width.
package sr_stack_pkg;

    typedef enum logic [1:0] {
        SR_STK_IDLE   = 2'd0,
        SR_STK_REFILL = 2'd1,
        SR_STK_DBGRD  = 2'd2
    } sr_stk_state_e;

    localparam int SR_STK_DEPTH_DEFAULT   = 16;
    localparam int SR_STK_WIDTH_DEFAULT   = 32;
    localparam int SR_STK_AW_DEFAULT      = 4;
    localparam int SR_STK_DBG_AGE_DEFAULT = 7;

    // Width of the debug starvation counter; must hold DBG_AGE.
    localparam int SR_STK_AGE_W = 3;

endpackage

// File: rtl/sr_stack_ram.sv
// Single-port RAM backing every stack entry below the top-of-stack.
// One access per cycle; reads are synchronous and rdata_o holds its value
// until the next read, so a capture one cycle later is always safe.
module sr_stack_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH-1];
    logic [WIDTH-1:0] rdata_q;

    // Single access port: write, or registered read.
    // NOTE: storage and read register carry no reset; the controller never
    // consumes a word it has not written, and a reset keeps the RAM mappable.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sr_stack_ctrl.sv
// Hardware stack controller for sr_cpu push/pop. Top-of-stack lives in a
// register, deeper entries in sr_stack_ram. Pops that leave entries behind
// refill the TOS register from RAM on the following cycle. A debug read
// port shares the RAM; the CPU wins arbitration until the debug request
// has aged DBG_AGE cycles, at which point the CPU is stalled for one cycle.
module sr_stack_ctrl
    import sr_stack_pkg::*;
#(
    parameter int DEPTH   = SR_STK_DEPTH_DEFAULT,
    parameter int WIDTH   = SR_STK_WIDTH_DEFAULT,
    parameter int AW      = SR_STK_AW_DEFAULT,
    parameter int DBG_AGE = SR_STK_DBG_AGE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_push,
    input  logic             cpu_pop,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             dbg_req,
    input  logic [AW-1:0]    dbg_idx,
    output logic [WIDTH-1:0] dbg_rdata,
    output logic             dbg_valid,
    output logic             dbg_err,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0]             CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]             CNT_ONE  = (AW+1)'(1);
    localparam logic [SR_STK_AGE_W-1:0] AGE_MAX  = SR_STK_AGE_W'(DBG_AGE);

    sr_stk_state_e           state_q, state_d;
    logic [AW:0]             count_q, count_d;
    logic [WIDTH-1:0]        tos_q, tos_d;
    logic [SR_STK_AGE_W-1:0] age_q, age_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    dbg_valid_q, dbg_valid_d;
    logic                    dbg_err_q, dbg_err_d;
    logic [WIDTH-1:0]        dbg_rdata_q, dbg_rdata_d;

    logic                    ram_en, ram_we;
    logic [AW-1:0]           ram_addr;
    logic [WIDTH-1:0]        ram_wdata, ram_rdata;

    logic is_empty, is_full;
    logic cpu_req, cpu_ram, cpu_ok;
    logic dbg_busy, dbg_pend, dbg_oor, dbg_imm, dbg_force, dbg_grant;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);
    assign cpu_req  = cpu_push | cpu_pop;

    // A lone push into a non-empty stack spills TOS; a lone pop that leaves
    // entries behind refills TOS. Push+pop swaps TOS and never touches RAM.
    assign cpu_ram = (cpu_push & ~cpu_pop & ~is_full & ~is_empty) |
                     (cpu_pop & ~cpu_push & (count_q > CNT_ONE));

    // A request whose result is in flight or being presented is not pending,
    // so a requester still holding dbg_req in the valid cycle is not re-served.
    assign dbg_busy  = (state_q == SR_STK_DBGRD) | dbg_valid_q;
    assign dbg_pend  = dbg_req & ~dbg_busy;
    assign dbg_oor   = ({1'b0, dbg_idx} >= count_q);
    assign dbg_imm   = dbg_oor | (dbg_idx == '0);
    assign dbg_force = (state_q == SR_STK_IDLE) & dbg_pend & (age_q == AGE_MAX);

    assign cpu_ok = cpu_req &
                    (((state_q == SR_STK_IDLE) & ~dbg_force) |
                     ((state_q == SR_STK_DBGRD) & ~cpu_ram));

    assign dbg_grant = (state_q == SR_STK_IDLE) & dbg_pend &
                       (dbg_force | dbg_imm | ~(cpu_ok & cpu_ram));

    assign cpu_stall = cpu_req & ~cpu_ok;

    // Next-state, RAM port and CPU read data for the stack FSM and arbiter.
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tos_d       = tos_q;
        age_d       = age_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        dbg_valid_d = 1'b0;
        dbg_err_d   = 1'b0;
        dbg_rdata_d = '0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = tos_q;
        cpu_rdata   = '0;

        if (state_q == SR_STK_REFILL) begin
            tos_d   = ram_rdata;
            state_d = SR_STK_IDLE;
        end

        if (state_q == SR_STK_DBGRD) begin
            dbg_valid_d = 1'b1;
            dbg_rdata_d = ram_rdata;
            state_d     = SR_STK_IDLE;
        end

        if (cpu_ok) begin
            case ({cpu_push, cpu_pop})
                2'b10: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        if (!is_empty) begin
                            ram_en   = 1'b1;
                            ram_we   = 1'b1;
                            ram_addr = AW'(count_q - CNT_ONE);
                        end
                        tos_d   = cpu_wdata;
                        count_d = count_q + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        cpu_rdata = tos_q;
                        count_d   = count_q - CNT_ONE;
                        if (count_q > CNT_ONE) begin
                            ram_en   = 1'b1;
                            ram_addr = AW'(count_q - CNT_ONE - CNT_ONE);
                            state_d  = SR_STK_REFILL;
                        end
                    end
                end
                2'b11: begin
                    tos_d = cpu_wdata;
                    if (is_empty) begin
                        unf_d   = 1'b1;
                        count_d = CNT_ONE;
                    end else begin
                        cpu_rdata = tos_q;
                    end
                end
                default: ;
            endcase
        end

        if (dbg_grant) begin
            if (dbg_imm) begin
                dbg_valid_d = 1'b1;
                dbg_err_d   = dbg_oor;
                dbg_rdata_d = dbg_oor ? '0 : tos_q;
            end else begin
                ram_en   = 1'b1;
                ram_we   = 1'b0;
                ram_addr = AW'(count_q - CNT_ONE - {1'b0, dbg_idx});
                state_d  = SR_STK_DBGRD;
            end
        end

        if (dbg_grant || !dbg_pend) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SR_STK_IDLE;
            count_q     <= '0;
            tos_q       <= '0;
            age_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            dbg_valid_q <= 1'b0;
            dbg_err_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tos_q       <= tos_d;
            age_q       <= age_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_err_q   <= dbg_err_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    sr_stack_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign count     = count_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign dbg_valid = dbg_valid_q;
    assign dbg_err   = dbg_err_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_sr_stack_ctrl.sv
// Directed bench for sr_stack_ctrl. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_sr_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_push, cpu_pop;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic [3:0]  dbg_idx;
    logic [31:0] dbg_rdata;
    logic        dbg_valid, dbg_err;
    logic [4:0]  count;
    logic        full, empty, overflow, underflow;

    int errors = 0;
    int checks = 0;

    sr_stack_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_push  (cpu_push),
        .cpu_pop   (cpu_pop),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_idx   (dbg_idx),
        .dbg_rdata (dbg_rdata),
        .dbg_valid (dbg_valid),
        .dbg_err   (dbg_err),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: drive, check combinational response, advance to next falling edge.
    task automatic cyc(input logic push, input logic pop, input logic [31:0] wd,
                       input logic exp_stall, input logic [31:0] exp_rdata, input string tag);
        cpu_push  = push;
        cpu_pop   = pop;
        cpu_wdata = wd;
        #1;
        check({tag, "_stall"}, 64'(cpu_stall), 64'(exp_stall));
        check({tag, "_rdata"}, 64'(cpu_rdata), 64'(exp_rdata));
        @(negedge clk);
        cpu_push = 1'b0;
        cpu_pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int stalls;
        int vcyc;

        rst = 1'b1; cpu_push = 1'b0; cpu_pop = 1'b0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_idx = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_dbg_valid", 64'(dbg_valid), 64'd0);
        check("rst_dbg_err", 64'(dbg_err), 64'd0);
        check("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_unf", 64'(underflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // LIFO order with refill stalls after the first two pops only.
        cyc(1, 0, 32'h11, 0, 0, "push11");
        cyc(1, 0, 32'h22, 0, 0, "push22");
        cyc(1, 0, 32'h33, 0, 0, "push33");
        cyc(0, 1, 0, 0, 32'h33, "pop1");
        cyc(0, 1, 0, 1, 0, "pop2_wait");
        cyc(0, 1, 0, 0, 32'h22, "pop2");
        cyc(0, 1, 0, 1, 0, "pop3_wait");
        cyc(0, 1, 0, 0, 32'h11, "pop3");
        cyc(0, 0, 0, 0, 0, "idle1");
        check("lifo_count", 64'(count), 64'd0);
        check("lifo_empty", 64'(empty), 64'd1);

        // Pop on empty, then push/pop recovers.
        cyc(0, 1, 0, 0, 0, "pop_empty");
        check("unf_flag", 64'(underflow), 64'd1);
        check("unf_count", 64'(count), 64'd0);
        cyc(1, 0, 32'h5, 0, 0, "push5");
        cyc(0, 1, 0, 0, 32'h5, "pop5");

        // Simultaneous push+pop with two entries: swap TOS, no stall.
        cyc(1, 0, 32'h3, 0, 0, "push3");
        cyc(1, 0, 32'h7, 0, 0, "push7");
        cyc(1, 1, 32'h9, 0, 32'h7, "swap");
        check("swap_count", 64'(count), 64'd2);
        cyc(0, 1, 0, 0, 32'h9, "pop9");
        cyc(0, 0, 0, 0, 0, "refill_idle");
        cyc(0, 1, 0, 0, 32'h3, "pop3b");

        // Debug reads with stack A, B, C(top).
        cyc(1, 0, 32'hA, 0, 0, "pushA");
        cyc(1, 0, 32'hB, 0, 0, "pushB");
        cyc(1, 0, 32'hC, 0, 0, "pushC");
        dbg_req = 1'b1; dbg_idx = 4'd2;
        @(negedge clk); #1;
        check("dbg2_wait_valid", 64'(dbg_valid), 64'd0);
        @(negedge clk); #1;
        check("dbg2_valid", 64'(dbg_valid), 64'd1);
        check("dbg2_rdata", 64'(dbg_rdata), 64'hA);
        check("dbg2_err", 64'(dbg_err), 64'd0);
        dbg_req = 1'b0;
        @(negedge clk); #1;
        check("dbg2_pulse_end", 64'(dbg_valid), 64'd0);
        dbg_req = 1'b1; dbg_idx = 4'd3;
        @(negedge clk); #1;
        check("dbg3_valid", 64'(dbg_valid), 64'd1);
        check("dbg3_err", 64'(dbg_err), 64'd1);
        check("dbg3_rdata", 64'(dbg_rdata), 64'd0);
        dbg_req = 1'b0;
        @(negedge clk);
        dbg_req = 1'b1; dbg_idx = 4'd0;
        @(negedge clk); #1;
        check("dbg0_valid", 64'(dbg_valid), 64'd1);
        check("dbg0_rdata", 64'(dbg_rdata), 64'hC);
        check("dbg0_err", 64'(dbg_err), 64'd0);
        dbg_req = 1'b0;
        @(negedge clk);

        // Reset while a debug RAM read is in flight: no valid pulse.
        dbg_req = 1'b1; dbg_idx = 4'd1;
        @(negedge clk); #1;
        check("dbgrst_inflight", 64'(dbg_valid), 64'd0);
        rst = 1'b1; dbg_req = 1'b0;
        @(negedge clk); #1;
        check("dbgrst_valid", 64'(dbg_valid), 64'd0);
        check("dbgrst_count", 64'(count), 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("dbgrst_after", 64'(dbg_valid), 64'd0);

        // Fill to capacity, overflow, then pop returns the 16th value.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 32'h100 + 32'(i), 0, 0, "fill");
        end
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd16);
        check("fill_ovf", 64'(overflow), 64'd0);
        cyc(1, 0, 32'hDEAD, 0, 0, "push17");
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_count", 64'(count), 64'd16);
        cyc(0, 1, 0, 0, 32'h10F, "pop_after_ovf");

        // Reset during the refill that pop started.
        rst = 1'b1;
        @(negedge clk); #1;
        check("refrst_count", 64'(count), 64'd0);
        check("refrst_ovf", 64'(overflow), 64'd0);
        check("refrst_empty", 64'(empty), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Push+pop on empty: underflow flagged, push still performed.
        cyc(1, 1, 32'h44, 0, 0, "swap_empty");
        check("swap_empty_unf", 64'(underflow), 64'd1);
        check("swap_empty_count", 64'(count), 64'd1);
        cyc(0, 1, 0, 0, 32'h44, "pop44");

        // Debug starvation: CPU pushes every cycle while dbg_req (idx 1) is held.
        // Nine entries first so the stack is full by the time debug is forced;
        // the push in the read-in-flight cycle then needs no RAM.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 32'h200 + 32'(i), 0, 0, "prefill");
        end
        dbg_req = 1'b1; dbg_idx = 4'd1;
        k = 0; stalls = 0; vcyc = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (dbg_valid) begin
                vcyc = c;
                break;
            end
            cpu_push = 1'b1; cpu_pop = 1'b0; cpu_wdata = 32'h300 + 32'(k);
            #1;
            if (cpu_stall) stalls++;
            else k++;
            @(negedge clk);
        end
        cpu_push = 1'b0;
        check("age_valid_cycle", 64'(vcyc), 64'd9);
        check("age_stalls", 64'(stalls), 64'd1);
        check("age_rdata", 64'(dbg_rdata), 64'h305);
        check("age_err", 64'(dbg_err), 64'd0);
        check("age_ovf", 64'(overflow), 64'd1);
        check("age_count", 64'(count), 64'd16);
        dbg_req = 1'b0;
        @(negedge clk); #1;
        check("age_pulse_end", 64'(dbg_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
